// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR read/write port among NUM_CORES solver cores.
// Latches the winning request, drives the upstream handshake and routes grants/beats back.
module ddr_port_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDX_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CORES-1:0]          core_rd_req,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_rd_addr,
  input  logic [NUM_CORES*LEN_W-1:0]    core_rd_len,
  output logic [NUM_CORES-1:0]          core_rd_grant,
  output logic [NUM_CORES-1:0]          core_rd_valid,
  output logic [DATA_W-1:0]             core_rd_data,
  input  logic [NUM_CORES-1:0]          core_wr_req,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_wr_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wr_data,
  output logic [NUM_CORES-1:0]          core_wr_grant,
  output logic                          ddr_read_req,
  output logic [ADDR_W-1:0]             ddr_read_addr,
  output logic [LEN_W-1:0]              ddr_read_len,
  input  logic                          ddr_read_grant,
  input  logic [DATA_W-1:0]             ddr_read_data,
  input  logic                          ddr_read_valid,
  output logic                          ddr_write_req,
  output logic [ADDR_W-1:0]             ddr_write_addr,
  output logic [DATA_W-1:0]             ddr_write_data,
  input  logic                          ddr_write_grant,
  output logic                          busy,
  output logic [IDX_W-1:0]              owner_idx,
  output logic                          err_timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  logic [1:0]           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     owner;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic [LEN_W-1:0]     rd_len_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic [LEN_W-1:0]     beat_cnt;
  logic [TMR_W-1:0]     timer;

  logic [NUM_CORES-1:0] cand;
  logic                 found;
  logic                 win_rd;
  logic [IDX_W-1:0]     win;
  logic [IDX_W:0]       probe;

  // Rotating search starting at rr_ptr; read beats write for the same core.
  always_comb begin
    cand   = core_rd_req | core_wr_req;
    found  = 1'b0;
    win_rd = 1'b0;
    win    = '0;
    probe  = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      probe = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (probe >= (IDX_W + 1)'(NUM_CORES))
        probe = probe - (IDX_W + 1)'(NUM_CORES);
      if (!found && cand[probe[IDX_W-1:0]]) begin
        found  = 1'b1;
        win    = probe[IDX_W-1:0];
        win_rd = core_rd_req[probe[IDX_W-1:0]];
      end
    end
  end

  logic [NUM_CORES-1:0] owner_oh;
  logic [LEN_W-1:0]     beats;
  logic                 beat_acc;
  logic                 rd_last;
  logic                 tmo;
  logic [IDX_W-1:0]     next_ptr;

  assign owner_oh = NUM_CORES'(1) << owner;
  assign beats    = (rd_len_q == '0) ? LEN_W'(1) : rd_len_q;
  assign beat_acc = ddr_read_valid &&
                    (((state == RD_REQ) && ddr_read_grant) || (state == RD_DATA));
  assign rd_last  = beat_acc && (({1'b0, beat_cnt} + (LEN_W + 1)'(1)) == {1'b0, beats});
  assign tmo      = (state == RD_DATA) && !beat_acc && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      rd_addr_q <= '0;
      rd_len_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      beat_cnt  <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner    <= win;
            beat_cnt <= '0;
            timer    <= '0;
            if (win_rd) begin
              rd_addr_q <= core_rd_addr[win*ADDR_W +: ADDR_W];
              rd_len_q  <= core_rd_len[win*LEN_W +: LEN_W];
              state     <= RD_REQ;
            end else begin
              wr_addr_q <= core_wr_addr[win*ADDR_W +: ADDR_W];
              wr_data_q <= core_wr_data[win*DATA_W +: DATA_W];
              state     <= WR_REQ;
            end
          end
        end
        RD_REQ: begin
          if (ddr_read_grant) begin
            if (rd_last) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end else begin
              state <= RD_DATA;
              timer <= '0;
              if (beat_acc) beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RD_DATA: begin
          if (rd_last || tmo) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (beat_acc) begin
            beat_cnt <= beat_cnt + 1'b1;
            timer    <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WR_REQ: begin
          if (ddr_write_grant) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ddr_read_req   = (state == RD_REQ);
  assign ddr_read_addr  = rd_addr_q;
  assign ddr_read_len   = rd_len_q;
  assign ddr_write_req  = (state == WR_REQ);
  assign ddr_write_addr = wr_addr_q;
  assign ddr_write_data = wr_data_q;
  assign core_rd_grant  = ((state == RD_REQ) && ddr_read_grant) ? owner_oh : '0;
  assign core_rd_valid  = beat_acc ? owner_oh : '0;
  assign core_rd_data   = ddr_read_data;
  assign core_wr_grant  = ((state == WR_REQ) && ddr_write_grant) ? owner_oh : '0;
  assign busy           = (state != IDLE);
  assign owner_idx      = owner;
  assign err_timeout    = tmo;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: requests push expected transactions to a
// scoreboard queue in expected service order; each serviced transaction pops one.
module tb_ddr_port_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int TMO = 8;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   core_rd_req;
  logic [NC*AW-1:0] core_rd_addr;
  logic [NC*LW-1:0] core_rd_len;
  logic [NC-1:0]   core_rd_grant;
  logic [NC-1:0]   core_rd_valid;
  logic [DW-1:0]   core_rd_data;
  logic [NC-1:0]   core_wr_req;
  logic [NC*AW-1:0] core_wr_addr;
  logic [NC*DW-1:0] core_wr_data;
  logic [NC-1:0]   core_wr_grant;
  logic            ddr_read_req;
  logic [AW-1:0]   ddr_read_addr;
  logic [LW-1:0]   ddr_read_len;
  logic            ddr_read_grant;
  logic [DW-1:0]   ddr_read_data;
  logic            ddr_read_valid;
  logic            ddr_write_req;
  logic [AW-1:0]   ddr_write_addr;
  logic [DW-1:0]   ddr_write_data;
  logic            ddr_write_grant;
  logic            busy;
  logic [IW-1:0]   owner_idx;
  logic            err_timeout;

  ddr_port_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_rd_req(core_rd_req), .core_rd_addr(core_rd_addr), .core_rd_len(core_rd_len),
    .core_rd_grant(core_rd_grant), .core_rd_valid(core_rd_valid), .core_rd_data(core_rd_data),
    .core_wr_req(core_wr_req), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_wr_grant(core_wr_grant),
    .ddr_read_req(ddr_read_req), .ddr_read_addr(ddr_read_addr), .ddr_read_len(ddr_read_len),
    .ddr_read_grant(ddr_read_grant), .ddr_read_data(ddr_read_data), .ddr_read_valid(ddr_read_valid),
    .ddr_write_req(ddr_write_req), .ddr_write_addr(ddr_write_addr), .ddr_write_data(ddr_write_data),
    .ddr_write_grant(ddr_write_grant),
    .busy(busy), .owner_idx(owner_idx), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            core;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
  } txn_t;

  txn_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req_rd(input int c, input logic [AW-1:0] a, input logic [LW-1:0] l);
    core_rd_req[c] = 1'b1;
    core_rd_addr[c*AW +: AW] = a;
    core_rd_len[c*LW +: LW] = l;
    sbq.push_back('{c, 1'b0, a, DW'(l)});
  endtask

  task automatic req_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_wr_req[c] = 1'b1;
    core_wr_addr[c*AW +: AW] = a;
    core_wr_data[c*DW +: DW] = d;
    sbq.push_back('{c, 1'b1, a, d});
  endtask

  task automatic wait_req(input bit wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ddr_read_valid  = 1'b0;
      ddr_read_grant  = 1'b0;
      ddr_write_grant = 1'b0;
      #1;
      if (wr ? ddr_write_req : ddr_read_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic serve_read(input int gdelay, input bit bgrant, input int nvalid, input bit tmo_exp);
    txn_t          e;
    bit            ok;
    logic [NC-1:0] oh;
    logic [DW-1:0] d;
    wait_req(1'b0, ok);
    chk("rd_req_seen", ok, 1);
    if (!ok || sbq.size() == 0) return;
    e = sbq.pop_front();
    oh = '0;
    oh[e.core] = 1'b1;
    chk("rd_owner", owner_idx, e.core);
    chk("rd_addr", ddr_read_addr, e.addr);
    chk("rd_len", ddr_read_len, e.val[LW-1:0]);
    chk("rd_busy", busy, 1);
    for (int i = 0; i < gdelay; i++) begin
      ddr_read_valid = 1'b1;
      #1;
      chk("pre_grant_valid", core_rd_valid, 0);
      chk("pre_grant", core_rd_grant, 0);
      @(negedge clk);
      ddr_read_valid = 1'b0;
      #1;
      chk("rd_req_held", ddr_read_req, 1);
    end
    d = $urandom;
    ddr_read_grant = 1'b1;
    ddr_read_valid = bgrant;
    ddr_read_data  = d;
    core_rd_req[e.core] = 1'b0;
    #1;
    chk("rd_grant", core_rd_grant, oh);
    chk("grant_beat", core_rd_valid, bgrant ? oh : '0);
    chk("grant_data", core_rd_data, d);
    for (int i = int'(bgrant); i < nvalid; i++) begin
      @(negedge clk);
      d = $urandom;
      ddr_read_grant = 1'b0;
      ddr_read_valid = 1'b1;
      ddr_read_data  = d;
      #1;
      chk("beat_valid", core_rd_valid, oh);
      chk("beat_data", core_rd_data, d);
      chk("rd_req_low", ddr_read_req, 0);
      chk("rd_grant_low", core_rd_grant, 0);
    end
    if (tmo_exp) begin
      for (int s = 1; s <= TMO; s++) begin
        @(negedge clk);
        ddr_read_grant = 1'b0;
        ddr_read_valid = 1'b0;
        #1;
        chk("err_timeout", err_timeout, (s == TMO));
        chk("tmo_busy", busy, 1);
      end
    end
    @(negedge clk);
    ddr_read_grant = 1'b0;
    ddr_read_valid = 1'b1;
    #1;
    chk("post_valid_ignored", core_rd_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_err", err_timeout, 0);
  endtask

  task automatic serve_write();
    txn_t          e;
    bit            ok;
    logic [NC-1:0] oh;
    wait_req(1'b1, ok);
    chk("wr_req_seen", ok, 1);
    if (!ok || sbq.size() == 0) return;
    e = sbq.pop_front();
    oh = '0;
    oh[e.core] = 1'b1;
    chk("wr_kind", e.wr, 1);
    chk("wr_owner", owner_idx, e.core);
    chk("wr_addr", ddr_write_addr, e.addr);
    chk("wr_data", ddr_write_data, e.val);
    chk("wr_no_grant", core_wr_grant, 0);
    chk("wr_no_rdreq", ddr_read_req, 0);
    @(negedge clk);
    #1;
    chk("wr_req_held", ddr_write_req, 1);
    ddr_write_grant = 1'b1;
    core_wr_req[e.core] = 1'b0;
    #1;
    chk("wr_grant", core_wr_grant, oh);
    @(negedge clk);
    ddr_write_grant = 1'b0;
    #1;
    chk("wr_post_busy", busy, 0);
    chk("wr_post_grant", core_wr_grant, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    txn_t e;
    rst_n = 1'b0;
    core_rd_req = '0; core_rd_addr = '0; core_rd_len = '0;
    core_wr_req = '0; core_wr_addr = '0; core_wr_data = '0;
    ddr_read_grant = 1'b0; ddr_read_data = '0; ddr_read_valid = 1'b0;
    ddr_write_grant = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner_idx, 0);
    chk("rst_rdreq", ddr_read_req, 0);
    chk("rst_wrreq", ddr_write_req, 0);
    chk("rst_rdaddr", ddr_read_addr, 0);
    chk("rst_wrdata", ddr_write_data, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_grant", core_rd_grant, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single read, core 2, grant after 3 cycles, 4 beats
    req_rd(2, 32'h100, 8'd4);
    serve_read(3, 1'b0, 4, 1'b0);

    // rr_ptr is 3 now: order 3,0,1,2
    req_rd(3, 32'h13, 8'd1);
    req_rd(0, 32'h10, 8'd1);
    req_rd(1, 32'h11, 8'd1);
    req_rd(2, 32'h12, 8'd1);
    repeat (4) serve_read(0, 1'b1, 1, 1'b0);

    // rr_ptr is 3: core 3 beats core 0 (not fixed priority)
    req_rd(3, 32'h23, 8'd1);
    req_rd(0, 32'h20, 8'd1);
    repeat (2) serve_read(0, 1'b1, 1, 1'b0);

    // rr_ptr is 1: core 1 read first, then core 2, then core 1 write
    req_rd(1, 32'h80, 8'd2);
    req_rd(2, 32'h90, 8'd1);
    req_wr(1, 32'h40, 32'hDEADBEEF);
    serve_read(0, 1'b0, 2, 1'b0);
    serve_read(1, 1'b1, 1, 1'b0);
    serve_write();

    // len 0: single beat in the grant cycle, valid before grant ignored
    req_rd(0, 32'h200, 8'd0);
    serve_read(1, 1'b1, 1, 1'b0);

    // timeout: 2 beats of 4 then silence
    req_rd(1, 32'h300, 8'd4);
    serve_read(0, 1'b0, 2, 1'b1);

    // reset during beat 2 of 4
    req_rd(2, 32'h500, 8'd4);
    wait_req(1'b0, ok);
    chk("mid_req_seen", ok, 1);
    if (sbq.size() != 0) e = sbq.pop_front();
    chk("mid_owner", owner_idx, e.core);
    ddr_read_grant = 1'b1;
    core_rd_req[2] = 1'b0;
    @(negedge clk);
    ddr_read_grant = 1'b0;
    ddr_read_valid = 1'b1;
    #1;
    chk("mid_beat1", core_rd_valid, 4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", core_rd_valid, 0);
    chk("mid_rst_rdaddr", ddr_read_addr, 0);
    chk("mid_rst_rdlen", ddr_read_len, 0);
    chk("mid_rst_owner", owner_idx, 0);
    chk("mid_rst_rdreq", ddr_read_req, 0);
    ddr_read_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // rr_ptr back to 0: core 1 precedes core 3
    req_rd(1, 32'h600, 8'd1);
    req_rd(3, 32'h700, 8'd2);
    serve_read(0, 1'b1, 1, 1'b0);
    serve_read(1, 1'b0, 2, 1'b0);

    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
